popcount_accum_ctrl: RTL
========================

# popcount_accum_ctrl

Sequencing controller around the existing 9-input popcount adder (`adder_9to4`). It takes a valid/ready stream of 9-bit binary 3×3 windows, such as XNOR products across input channels, and counts the set bits of each window. It accumulates those counts over a configurable number of beats per output pixel and presents one accumulated sum per group on a valid/ready output. It sits between the binary window generator and the threshold/activation stage of the binary-conv path.

## Interface
Parameters:
- `CNT_W`, default 8: width of the beat counter and of `cfg_len`.
- `ACC_W`, default `CNT_W+4`: accumulator and output width. This holds 9×(2^CNT_W−1) without overflow.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `flush`  in  1  synchronous abort; discards any partial or pending group.
- `cfg_len`  in  CNT_W  beats per group; 0 is treated as 1; sampled only on the first beat of a group.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  controller can accept a beat.
- `in_data`  in  9  binary window, one bit per tap.
- `out_valid`  out  1  `out_sum` holds a completed group.
- `out_ready`  in  1  downstream accepts `out_sum`.
- `out_sum`  out  ACC_W  accumulated popcount of the group.
- `busy`  out  1  high in ACCUM or DONE.

## Operation
- A beat transfers when `in_valid && in_ready`. A result transfers when `out_valid && out_ready`.
- Each beat's popcount `pop` (0..9) is the combinational output of one `adder_9to4` instance. It is zero-extended to ACC_W.
- The group length `len_eff` is `max(cfg_len,1)`. It is latched into `len_q` on the first beat of a group. Later changes to `cfg_len` do not affect the group in progress.

State machine:
- IDLE
  - Outputs: `in_ready=1`; `acc=0`, `cnt=0`.
  - On a beat: `acc←pop`, `cnt←1`, `len_q←len_eff`.
  - Next state is DONE if `len_eff==1`, otherwise ACCUM.
- ACCUM
  - Outputs: `in_ready=1`.
  - On a beat: `acc←acc+pop`, `cnt←cnt+1`.
  - If `cnt+1==len_q`, next state is DONE.
  - With no beat, state holds.
- DONE
  - Outputs: `in_ready=0`, `out_valid=1`, `out_sum=acc`.
  - `out_sum` is held stable until the result transfers.
  - On transfer: go to IDLE and clear `acc` and `cnt`.
- Priority is `reset` > `flush` > normal operation.
  - `flush` in any state forces IDLE and clears `acc`, `cnt` and `out_valid` on the next edge.
  - A beat or output handshake in the same cycle as `flush` is discarded.
- There is no overlap: the first beat of the next group is not accepted while in DONE.
- Arithmetic is unsigned. There is no saturation; the parameter rule above guarantees the accumulator never overflows.

## Timing
- Reset values:
  - state = IDLE
  - `acc=0`, `cnt=0`, `len_q=0`
  - `in_ready=1`, `out_valid=0`, `out_sum=0`, `busy=0`
- `in_ready` and `out_valid` are registered-state decodes. There is no combinational path from `in_valid` or `out_ready` to either.
- Latency: `out_valid` rises on the cycle after the edge that accepted the last beat of the group.
- Throughput:
  - One beat per cycle during a group.
  - Minimum one DONE cycle per group, so a group of N beats occupies at least N+1 cycles.
- `out_ready` low holds the controller in DONE indefinitely. `in_ready` stays 0 for that whole time.
- Reset or flush mid-group causes no output; the next accepted beat starts a fresh group.

## Structure
- Shared package `popcount_pkg`:
  - state enum `{IDLE, ACCUM, DONE}`
  - a function computing ACC_W from CNT_W
  - the constant `POP_W=4`
- One sub-module only: the existing `adder_9to4`, instantiated once on `in_data`.
- The rest is a single always block for state, `acc`, `cnt` and `len_q`, plus output decode.

## Test plan
- `cfg_len=1`, one beat `0x1FF` → `out_valid` one cycle later; `out_sum=9`; `busy` high for exactly one cycle.
- `cfg_len=4`, beats `0x1FF`, `0x000`, `0x155`, `0x0AA` back-to-back → `out_sum=18`; `in_ready=0` in DONE.
- Same group with `out_ready` low for 3 cycles → `out_sum` stable at 18 for 4 cycles; no extra beat accepted; IDLE after the handshake.
- `cfg_len=255`, 255 beats of `0x1FF` → `out_sum=2295`. Then `cfg_len=0`, one beat `0x007` → `out_sum=3`.
- `cfg_len=3`; change `cfg_len` to 1 after the first beat → the group still takes 3 beats. `flush` after 2 beats → `busy=0`, no `out_valid`, and the next group sums from 0.
- `reset` asserted in DONE with `out_ready=1` in the same cycle → no transfer counted; all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/popcount_pkg.sv
// Shared types and constants for the popcount accumulation controller.
package popcount_pkg;

  // Width of a single 9-tap popcount (0..9).
  localparam int POP_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Accumulator width that holds 9 * (2^cnt_w - 1) without overflow.
  function automatic int acc_width(input int cnt_w);
    return cnt_w + 4;
  endfunction

endpackage

// File: rtl/adder_9to4.sv
// 9-input popcount adder: counts the set bits of a 3x3 binary window.
module adder_9to4
  import popcount_pkg::*;
(
  input  logic [8:0]       a_i,
  output logic [POP_W-1:0] sum_o
);

  // Purely combinational bit count over the nine taps.
  always_comb begin
    sum_o = '0;
    for (int i = 0; i < 9; i++) begin
      sum_o = sum_o + {{(POP_W-1){1'b0}}, a_i[i]};
    end
  end

endmodule

// File: rtl/popcount_accum_ctrl.sv
// Sequencing controller: accumulates per-beat popcounts over a group of
// cfg_len beats and presents one sum per group on a valid/ready output.
module popcount_accum_ctrl
  import popcount_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int ACC_W = acc_width(CNT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             busy
);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;

  logic [POP_W-1:0]   pop;
  logic [ACC_W-1:0]   pop_ext;
  logic [CNT_W-1:0]   len_eff;
  logic [CNT_W-1:0]   cnt_inc;

  adder_9to4 u_adder (
    .a_i   (in_data),
    .sum_o (pop)
  );

  assign pop_ext = ACC_W'(pop);
  // A zero length would never terminate a group, so it behaves as one beat.
  assign len_eff = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Outputs decode registered state only; no combinational path from
  // in_valid/out_ready to the handshake outputs.
  assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_sum   = out_valid ? acc_q : '0;
  assign busy      = (state_q == ACCUM) || (state_q == DONE);

  // Next-state and datapath update; flush overrides any same-cycle handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (flush) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_d   = pop_ext;
            cnt_d   = CNT_W'(1);
            len_d   = len_eff;
            state_d = (len_eff == CNT_W'(1)) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_d = acc_q + pop_ext;
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, accumulator, beat counter and latched group length.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

endmodule
